// File: rtl/parity_engine.sv
// Shared UART parity unit: a registered TX parity generator and a serial RX
// parity checker. The two paths share only the configuration inputs.
module parity_engine #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PAR_EN,
  input  logic [1:0]       PAR_TYP,
  input  logic [LEN_W-1:0] DATA_LEN,
  input  logic [WIDTH-1:0] DATA,
  input  logic             DATA_VALID,
  input  logic             BUSY,
  output logic             parity,
  output logic             parity_valid,
  input  logic             RX_START,
  input  logic             RX_BIT,
  input  logic             RX_BIT_VALID,
  output logic             PAR_ERR,
  output logic             CHK_DONE,
  output logic             CHK_BUSY,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PARB = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  // Out-of-range lengths (0 or above WIDTH) fall back to the full word.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > WIDTH_L) clamp_len = WIDTH_L;
    else clamp_len = len;
  endfunction

  // x is the XOR of the data bits; the result is the parity bit to send.
  function automatic logic par_fn(input logic x, input logic [1:0] typ);
    case (typ)
      2'b00:   par_fn = x;
      2'b01:   par_fn = ~x;
      2'b10:   par_fn = 1'b1;
      default: par_fn = 1'b0;
    endcase
  endfunction

  // TX path
  logic             parity_q, parity_d;
  logic             parity_valid_q, parity_valid_d;
  logic             tx_cap;
  logic [LEN_W-1:0] tx_len;
  logic             tx_x;

  always_comb begin
    tx_cap = DATA_VALID && !BUSY && PAR_EN;
    tx_len = clamp_len(DATA_LEN);
    tx_x   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(tx_len)) tx_x = tx_x ^ DATA[i];
    end
    parity_d       = tx_cap ? par_fn(tx_x, PAR_TYP) : parity_q;
    parity_valid_d = tx_cap;
  end

  // RX path
  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       typ_q, typ_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      acc_q          <= 1'b0;
      cnt_q          <= '0;
      len_q          <= '0;
      typ_q          <= 2'b00;
      err_q          <= 1'b0;
      done_q         <= 1'b0;
      parity_q       <= 1'b0;
      parity_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      typ_q          <= typ_d;
      err_q          <= err_d;
      done_q         <= done_d;
      parity_q       <= parity_d;
      parity_valid_q <= parity_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    typ_d   = typ_q;
    err_d   = err_q;
    done_d  = 1'b0;
    // RX_START outranks any bit arriving in the same cycle, in every state.
    if (RX_START && (state_q != S_IDLE || PAR_EN)) begin
      if (PAR_EN) begin
        state_d = S_DATA;
        acc_d   = 1'b0;
        cnt_d   = '0;
        len_d   = clamp_len(DATA_LEN);
        typ_d   = PAR_TYP;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_DATA: begin
          if (RX_BIT_VALID) begin
            acc_d = acc_q ^ RX_BIT;
            cnt_d = cnt_q + LEN_W'(1);
            if (cnt_q + LEN_W'(1) == len_q) state_d = S_PARB;
          end
        end
        S_PARB: begin
          if (RX_BIT_VALID) begin
            err_d   = (RX_BIT != par_fn(acc_q, typ_q));
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    parity       = parity_q;
    parity_valid = parity_valid_q;
    PAR_ERR      = err_q;
    CHK_DONE     = done_q;
    CHK_BUSY     = (state_q != S_IDLE);
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_parity_engine.sv
// Directed bench for parity_engine: TX generation, length clamp, blocking,
// RX checking, frame abort and mid-frame reset.
module tb_parity_engine;

  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst;
  logic             par_en;
  logic [1:0]       par_typ;
  logic [LEN_W-1:0] data_len;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             busy;
  logic             parity;
  logic             parity_valid;
  logic             rx_start;
  logic             rx_bit;
  logic             rx_bit_valid;
  logic             par_err;
  logic             chk_done;
  logic             chk_busy;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  parity_engine #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .CLK(clk), .RST(rst), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .DATA_LEN(data_len), .DATA(data), .DATA_VALID(data_valid), .BUSY(busy),
    .parity(parity), .parity_valid(parity_valid),
    .RX_START(rx_start), .RX_BIT(rx_bit), .RX_BIT_VALID(rx_bit_valid),
    .PAR_ERR(par_err), .CHK_DONE(chk_done), .CHK_BUSY(chk_busy),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (chk_done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture one word and check the pulse, the value, and that it holds.
  task automatic tx_capture(input string name, input logic [7:0] d,
                            input logic [LEN_W-1:0] len, input logic [1:0] typ,
                            input logic exp_par);
    data = d; data_len = len; par_typ = typ; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    n_checks++;
    if (parity_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_valid: got %b want 1", name, parity_valid);
    end
    n_checks++;
    if (parity !== exp_par) begin
      n_fail++; $display("FAIL %s_parity: got %b want %b", name, parity, exp_par);
    end
    par_typ = ~typ;
    data = ~d;
    tick();
    n_checks++;
    if (parity_valid !== 1'b0 || parity !== exp_par) begin
      n_fail++;
      $display("FAIL %s_hold: got valid=%b parity=%b want valid=0 parity=%b",
               name, parity_valid, parity, exp_par);
    end
  endtask

  task automatic rx_send(input logic b);
    rx_bit = b; rx_bit_valid = 1'b1;
    tick();
    rx_bit_valid = 1'b0;
  endtask

  task automatic rx_begin(input logic [LEN_W-1:0] len, input logic [1:0] typ);
    data_len = len; par_typ = typ; rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (parity !== 1'b0 || parity_valid !== 1'b0 || par_err !== 1'b0 ||
        chk_done !== 1'b0 || chk_busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: got par=%b pv=%b err=%b done=%b busy=%b st=%0d want all 0",
               parity, parity_valid, par_err, chk_done, chk_busy, dbg_state);
    end
  endtask

  task automatic test_even_odd();
    tx_capture("even_a7", 8'hA7, 4'd8, 2'b00, 1'b1);
    tx_capture("odd_a7", 8'hA7, 4'd8, 2'b01, 1'b0);
  endtask

  task automatic test_length();
    tx_capture("len5_f3", 8'hF3, 4'd5, 2'b00, 1'b1);
    tx_capture("len0_f3", 8'hF3, 4'd0, 2'b00, 1'b0);
    tx_capture("len15_f3", 8'hF3, 4'd15, 2'b00, 1'b0);
    tx_capture("len1_02", 8'h02, 4'd1, 2'b01, 1'b1);
  endtask

  task automatic test_mark_space_block();
    tx_capture("mark_00", 8'h00, 4'd8, 2'b10, 1'b1);
    tx_capture("space_01", 8'h01, 4'd8, 2'b11, 1'b0);
    // parity is now 0; mark captures that are blocked must not change it
    busy = 1'b1; data = 8'h00; par_typ = 2'b10; data_valid = 1'b1;
    tick();
    n_checks++;
    if (parity_valid !== 1'b0 || parity !== 1'b0) begin
      n_fail++; $display("FAIL busy_block: got pv=%b par=%b want pv=0 par=0",
                         parity_valid, parity);
    end
    busy = 1'b0; par_en = 1'b0;
    tick();
    n_checks++;
    if (parity_valid !== 1'b0 || parity !== 1'b0) begin
      n_fail++; $display("FAIL en_block: got pv=%b par=%b want pv=0 par=0",
                         parity_valid, parity);
    end
    data_valid = 1'b0; par_en = 1'b1;
    tick();
  endtask

  task automatic test_rx_check();
    logic [7:0] d;
    d = 8'hA7;
    for (int pass = 0; pass < 2; pass++) begin
      rx_begin(4'd8, 2'b00);
      n_checks++;
      if (chk_busy !== 1'b1) begin
        n_fail++; $display("FAIL rx_busy_%0d: got %b want 1", pass, chk_busy);
      end
      for (int i = 0; i < 8; i++) rx_send(d[i]);
      n_checks++;
      if (chk_done !== 1'b0 || chk_busy !== 1'b1) begin
        n_fail++; $display("FAIL rx_pre_parb_%0d: got done=%b busy=%b want 0 1",
                           pass, chk_done, chk_busy);
      end
      rx_send(pass == 0 ? 1'b1 : 1'b0);
      n_checks++;
      if (chk_done !== 1'b1 || par_err !== (pass == 1)) begin
        n_fail++; $display("FAIL rx_check_%0d: got done=%b err=%b want done=1 err=%b",
                           pass, chk_done, par_err, pass == 1);
      end
      tick();
      n_checks++;
      if (chk_done !== 1'b0 || chk_busy !== 1'b0) begin
        n_fail++; $display("FAIL rx_after_%0d: got done=%b busy=%b want 0 0",
                           pass, chk_done, chk_busy);
      end
    end
  endtask

  task automatic test_rx_abort();
    logic [7:0] d;
    int done_before;
    d = 8'h55;
    done_before = done_cnt;
    rx_begin(4'd8, 2'b00);
    for (int i = 0; i < 4; i++) rx_send(1'b0);
    // restart with a 1 bit that must not be accumulated
    data_len = 4'd7; par_typ = 2'b01; rx_start = 1'b1; rx_bit = 1'b1; rx_bit_valid = 1'b1;
    tick();
    rx_start = 1'b0; rx_bit_valid = 1'b0;
    n_checks++;
    if (chk_busy !== 1'b1 || chk_done !== 1'b0 || par_err !== 1'b1) begin
      n_fail++; $display("FAIL abort_state: got busy=%b done=%b err=%b want 1 0 1",
                         chk_busy, chk_done, par_err);
    end
    par_typ = 2'b00;
    for (int i = 0; i < 7; i++) rx_send(d[i]);
    rx_send(1'b1);
    n_checks++;
    if (chk_done !== 1'b1 || par_err !== 1'b0) begin
      n_fail++; $display("FAIL abort_check: got done=%b err=%b want 1 0", chk_done, par_err);
    end
    tick();
    n_checks++;
    if (done_cnt - done_before !== 1 || chk_busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_count: got dones=%0d busy=%b want 1 0",
                         done_cnt - done_before, chk_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    rx_begin(4'd8, 2'b00);
    rx_send(1'b1);
    rx_send(1'b1);
    data = 8'hA7; data_len = 4'd8; data_valid = 1'b1;
    rx_send(1'b1);
    data_valid = 1'b0;
    n_checks++;
    if (parity_valid !== 1'b1 || parity !== 1'b1 || chk_busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got pv=%b par=%b busy=%b want 1 1 1",
                         parity_valid, parity, chk_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (parity !== 1'b0 || parity_valid !== 1'b0 || par_err !== 1'b0 ||
        chk_done !== 1'b0 || chk_busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got par=%b pv=%b err=%b done=%b busy=%b st=%0d want all 0",
               parity, parity_valid, par_err, chk_done, chk_busy, dbg_state);
    end
    d = 8'h0F;
    rx_begin(4'd8, 2'b00);
    for (int i = 0; i < 8; i++) rx_send(d[i]);
    rx_send(1'b1);
    n_checks++;
    if (chk_done !== 1'b1 || par_err !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_frame: got done=%b err=%b want 1 1", chk_done, par_err);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; par_en = 1'b1; par_typ = 2'b00; data_len = 4'd8; data = '0;
    data_valid = 1'b0; busy = 1'b0; rx_start = 1'b0; rx_bit = 1'b0; rx_bit_valid = 1'b0;
    test_reset();
    test_even_odd();
    test_length();
    test_mark_space_block();
    test_rx_check();
    test_rx_abort();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_engine.md
Name: parity_engine

Overview:
- Parametrised parity unit shared by the UART TX and RX paths.
- TX side: captures a data word when the transmitter is idle and produces its parity bit. Data length (1..WIDTH) and parity mode (even/odd/mark/space) are selected at run time.
- RX side: accumulates parity serially over incoming data bits, compares against the received parity bit and flags errors.

Parameters:
- WIDTH, 8, maximum data word width in bits (≥2).
- LEN_W, $clog2(WIDTH+1), width of DATA_LEN.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- PAR_EN  input  1  parity enable for both TX and RX.
- PAR_TYP  input  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
- DATA_LEN  input  LEN_W  active data bits, 1..WIDTH.
- DATA  input  WIDTH  TX data word.
- DATA_VALID  input  1  TX data word valid.
- BUSY  input  1  transmitter busy; blocks capture.
- parity  output  1  TX parity bit.
- parity_valid  output  1  one-cycle pulse when parity updates.
- RX_START  input  1  pulse marking start of an RX frame.
- RX_BIT  input  1  received serial bit (data LSB first, then parity bit).
- RX_BIT_VALID  input  1  RX_BIT qualifier.
- PAR_ERR  output  1  result of the last completed RX check.
- CHK_DONE  output  1  one-cycle pulse when an RX check completes.
- CHK_BUSY  output  1  high while an RX frame is in progress.

Behaviour:

Reset:
- Clock and reset: single clock CLK; RST is synchronous and active-high. All state updates on the rising edge of CLK.
- RST=1 at any time, including mid-frame: parity, parity_valid, PAR_ERR, CHK_DONE and CHK_BUSY are 0; FSM goes to IDLE; accumulator and counter cleared.

Length and mode rules:
- Effective length L = DATA_LEN when 1 ≤ DATA_LEN ≤ WIDTH; otherwise L = WIDTH (clamp).
- Only bits [L-1:0] contribute; bits ≥L are ignored.
- Parity function on ones-count X of the L data bits:
  - even: XOR of the data bits (total ones including parity is even).
  - odd: inverse of even.
  - mark: 1.
  - space: 0.

TX path:
- Capture occurs when DATA_VALID=1, BUSY=0 and PAR_EN=1. PAR_TYP, DATA_LEN and DATA are all sampled in that cycle.
- parity is registered and appears one cycle after capture; parity_valid pulses high for exactly that cycle.
- parity holds its value until the next capture.
- If PAR_EN=0 or BUSY=1: no capture, parity unchanged, no parity_valid pulse.
- Mode or length changes between captures do not affect the held parity.

RX path (FSM states IDLE, DATA, PARB):
- IDLE:
  - RX_START=1 and PAR_EN=1 → latch PAR_TYP and L, clear accumulator and bit counter, go to DATA.
  - RX_START with PAR_EN=0 is ignored.
  - RX_BIT_VALID is ignored.
- DATA:
  - Each RX_BIT_VALID XORs RX_BIT into the accumulator and increments the counter.
  - On the L-th valid bit, go to PARB.
- PARB:
  - On RX_BIT_VALID, compute expected = f(accumulator, latched mode).
  - PAR_ERR <= (RX_BIT != expected).
  - CHK_DONE pulses for 1 cycle (same cycle PAR_ERR updates); go to IDLE.
- RX_START in DATA or PARB aborts the current frame: no CHK_DONE, PAR_ERR unchanged, restart as from IDLE (re-latch config).
- RX_START and RX_BIT_VALID in the same cycle: start wins; that bit is not accumulated.
- PAR_EN and PAR_TYP changes mid-frame have no effect (config is latched).
- PAR_ERR holds until the next CHK_DONE or reset.
- CHK_BUSY = (state != IDLE).
- TX and RX paths are fully independent and may operate in the same cycle.

Test Plan:
1. Even/odd TX: WIDTH=8, L=8, DATA=8'hA7 (5 ones), capture with even mode → parity=1, parity_valid pulse one cycle later. Repeat with odd mode → parity=0.
2. Length mask and clamp:
   - DATA=8'hF3, DATA_LEN=5 (low bits 10011, 3 ones), even → parity=1.
   - DATA_LEN=0, clamped to 8 (6 ones), even → parity=0.
3. Mark/space and blocking:
   - Mark → 1 and space → 0 for any DATA.
   - DATA_VALID with BUSY=1, or with PAR_EN=0 → no parity_valid, parity unchanged.
4. RX check, L=8, even: RX_START, then bits of 8'hA7 LSB first, then parity bit 1 → CHK_DONE pulse, PAR_ERR=0. Repeat with parity bit 0 → PAR_ERR=1.
5. RX abort: RX_START, 4 bits, RX_START again (with RX_BIT_VALID in the same cycle), then a full L=7 odd frame of 7'h55 plus parity bit 1 → exactly one CHK_DONE, PAR_ERR=0, CHK_BUSY low afterwards.
6. Reset mid-frame: RST=1 after 3 RX bits and one cycle after a TX capture → all outputs 0 and CHK_BUSY=0 on the next cycle. The following clean frame checks correctly.
